// File: rtl/uart_mmio_pkg.sv
// Shared constants for the UART MMIO bridge: register offsets,
// STATUS/CTRL bit positions and the access FSM state encoding.
package uart_mmio_pkg;

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_IRQ      = 2;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;
    localparam int CTRL_W     = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_TX = 2'd1,
        S_RESP    = 2'd2
    } state_e;

    // Word index of a byte offset; the low two address bits are ignored.
    function automatic logic [5:0] word_of(input logic [7:0] off);
        return off[7:2];
    endfunction

endpackage

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped CPU window onto UART RX/TX FIFOs with a 3-state access FSM.
// Ports: clk, reset (async, active-low); CPU side sel/we/addr/wdata ->
// rdata/ready; FIFO side rd_uart/r_data/rx_empty, wr_uart/w_data/tx_full;
// irq level output. Define UART_IRQ_EN to enable the CTRL interrupt enables;
// otherwise CTRL reads 0 and irq is held low.
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DBIT   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              rd_uart,
    input  logic [7:0]        r_data,
    input  logic              rx_empty,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    input  logic              tx_full,
    output logic              irq
);

    localparam int WW = ADDR_W - 2;

    state_e            state_q, state_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rd_uart_q, rd_uart_d;
    logic              wr_uart_q, wr_uart_d;
    logic [7:0]        w_data_q, w_data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              irq_q, irq_d;

    logic [WW-1:0] word;
    logic          hit_tx, hit_rx, hit_st, hit_ctrl;
    logic [7:0]    tx_byte;
    logic [31:0]   status;
    logic          unused_ok;

    assign word     = addr[ADDR_W-1:2];
    assign hit_tx   = (word == WW'(word_of(OFF_TXDATA)));
    assign hit_rx   = (word == WW'(word_of(OFF_RXDATA)));
    assign hit_st   = (word == WW'(word_of(OFF_STATUS)));
    assign hit_ctrl = (word == WW'(word_of(OFF_CTRL)));

    // Characters narrower than a byte are zero-extended onto the FIFO bus.
    assign tx_byte   = 8'(wdata[DBIT-1:0]);
    assign unused_ok = ^{addr[1:0], wdata};

    always_comb begin
        status              = '0;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_IRQ]      = irq_q;
    end

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        rd_uart_d = 1'b0;
        wr_uart_d = 1'b0;
        w_data_d  = w_data_q;
        ctrl_d    = ctrl_q;

        unique case (state_q)
            S_IDLE: begin
                if (sel) begin
                    rdata_d = '0;
                    state_d = S_RESP;
                    if (we) begin
                        if (hit_tx) begin
                            w_data_d = tx_byte;
                            if (tx_full) begin
                                state_d = S_WAIT_TX;
                            end else begin
                                wr_uart_d = 1'b1;
                            end
                        end
`ifdef UART_IRQ_EN
                        if (hit_ctrl) begin
                            ctrl_d = wdata[CTRL_W-1:0];
                        end
`endif
                    end else begin
                        case (1'b1)
                            hit_rx: begin
                                // FWFT head is captured as the pop is issued.
                                if (!rx_empty) begin
                                    rdata_d   = {23'b0, 1'b1, r_data};
                                    rd_uart_d = 1'b1;
                                end
                            end
                            hit_st:   rdata_d = status;
                            hit_ctrl: rdata_d = 32'(ctrl_q);
                            default:  rdata_d = '0;
                        endcase
                    end
                end
            end
            S_WAIT_TX: begin
                if (!tx_full) begin
                    wr_uart_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef UART_IRQ_EN
    always_comb begin
        irq_d = (ctrl_q[CTRL_RX_IE] & ~rx_empty)
              | (ctrl_q[CTRL_TX_IE] & ~tx_full);
    end
`else
    always_comb begin
        irq_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rdata_q   <= '0;
            rd_uart_q <= 1'b0;
            wr_uart_q <= 1'b0;
            w_data_q  <= '0;
            ctrl_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            rd_uart_q <= rd_uart_d;
            wr_uart_q <= wr_uart_d;
            w_data_q  <= w_data_d;
            ctrl_q    <= ctrl_d;
            irq_q     <= irq_d;
        end
    end

    assign ready   = (state_q == S_RESP);
    assign rdata   = rdata_q;
    assign rd_uart = rd_uart_q;
    assign wr_uart = wr_uart_q;
    assign w_data  = w_data_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Randomized self-checking bench for uart_mmio_bridge with a
// register-map reference model; honours UART_IRQ_EN like the design.
module tb_uart_mmio_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel, we;
    logic [4:0]  addr;
    logic [31:0] wdata, rdata;
    logic        ready, rd_uart, wr_uart, rx_empty, tx_full, irq;
    logic [7:0]  r_data, w_data;

    int errors = 0;
    int checks = 0;
    int overlap = 0;
    logic [1:0] ctrl_m = 2'b00;

    always #5 clk = ~clk;

    uart_mmio_bridge #(.ADDR_W(5), .DBIT(8)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready),
        .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty),
        .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full),
        .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic irq_model(input logic [1:0] c,
                                       input logic rxe, input logic txf);
`ifdef UART_IRQ_EN
        return (c[0] && !rxe) || (c[1] && !txf);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] read_model(input logic [4:0] a,
            input logic rxe, input logic [7:0] rd, input logic txf,
            input logic irqv, input logic [1:0] c);
        case (a / 4)
            1: return rxe ? 32'd0 : 32'd256 + 32'(rd);
            2: return 32'(irqv) * 4 + 32'(txf) * 2 + 32'(rxe);
`ifdef UART_IRQ_EN
            3: return 32'(c);
`endif
            default: return 32'd0;
        endcase
    endfunction

    // One CPU access; returns read data, ready latency in cycles counted
    // from the clock edge that launched sel, and strobe/ready counts
    // including one trailing cycle.
    task automatic access(input logic w, input logic [4:0] a,
                          input logic [31:0] d, input int stall,
                          output logic [31:0] rd, output int lat,
                          output int nrd, output int nwr,
                          output logic [7:0] wd, output int nrdy);
        bit done = 0;
        @(negedge clk);
        sel = 1'b1; we = w; addr = a; wdata = d;
        rd = '0; lat = -1; nrd = 0; nwr = 0; wd = '0; nrdy = 0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_uart) nrd++;
            if (wr_uart) begin nwr++; wd = w_data; end
            if (rd_uart && wr_uart) overlap++;
            if (c == stall) tx_full = 1'b0;
            if (ready) begin
                done = 1; lat = c + 1; rd = rdata; nrdy++;
            end
        end
        sel = 1'b0; we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (rd_uart) nrd++;
        if (wr_uart) nwr++;
        if (ready) nrdy++;
    endtask

    logic [31:0] rd_v;
    logic [7:0]  wd_v;
    int lat_v, nrd_v, nwr_v, nrdy_v;

    initial begin
        reset = 1'b0; sel = 0; we = 0; addr = '0; wdata = '0;
        r_data = '0; rx_empty = 1'b1; tx_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 0);
        check("rst_rdata", rdata, 0);
        check("rst_strobes", 32'({rd_uart, wr_uart}), 0);
        check("rst_wdata", 32'(w_data), 0);
        check("rst_irq", 32'(irq), 0);
        reset = 1'b1;

        // TXDATA write, no stall
        access(1, 5'h00, 32'hABCD_0041, 0, rd_v, lat_v, nrd_v, nwr_v,
               wd_v, nrdy_v);
        check("tx_lat", 32'(lat_v), 2);
        check("tx_nwr", 32'(nwr_v), 1);
        check("tx_wdata", 32'(wd_v), 32'h41);
        check("tx_nrdy", 32'(nrdy_v), 1);

        // TXDATA write stalled 5 cycles
        tx_full = 1'b1;
        access(1, 5'h00, 32'h55, 5, rd_v, lat_v, nrd_v, nwr_v, wd_v, nrdy_v);
        check("stall_lat", 32'(lat_v), 7);
        check("stall_nwr", 32'(nwr_v), 1);
        check("stall_wdata", 32'(wd_v), 32'h55);

        // RXDATA reads
        r_data = 8'h7E; rx_empty = 1'b0;
        access(0, 5'h04, 0, 0, rd_v, lat_v, nrd_v, nwr_v, wd_v, nrdy_v);
        check("rx_data", rd_v, 32'h0000_017E);
        check("rx_nrd", 32'(nrd_v), 1);
        rx_empty = 1'b1;
        access(0, 5'h04, 0, 0, rd_v, lat_v, nrd_v, nwr_v, wd_v, nrdy_v);
        check("rx_empty_data", rd_v, 0);
        check("rx_empty_nrd", 32'(nrd_v), 0);

        // STATUS and unmapped
        tx_full = 1'b1; rx_empty = 1'b1;
        access(0, 5'h08, 0, 0, rd_v, lat_v, nrd_v, nwr_v, wd_v, nrdy_v);
        check("status", rd_v, 32'h3);
        tx_full = 1'b0;
        access(0, 5'h14, 0, 0, rd_v, lat_v, nrd_v, nwr_v, wd_v, nrdy_v);
        check("unmapped_data", rd_v, 0);
        check("unmapped_nrdy", 32'(nrdy_v), 1);

        // CTRL / irq
        tx_full = 1'b1; rx_empty = 1'b1;
        access(1, 5'h0C, 32'h1, 0, rd_v, lat_v, nrd_v, nwr_v, wd_v, nrdy_v);
`ifdef UART_IRQ_EN
        ctrl_m = 2'b01;
`endif
        check("irq_before", 32'(irq), 0);
        rx_empty = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("irq_after", 32'(irq), 32'(irq_model(ctrl_m, 1'b0, 1'b1)));
        access(0, 5'h0C, 0, 0, rd_v, lat_v, nrd_v, nwr_v, wd_v, nrdy_v);
        check("ctrl_rd", rd_v, 32'(ctrl_m));

        // Reset during WAIT_TX
        @(negedge clk);
        tx_full = 1'b1; sel = 1; we = 1; addr = 5'h00; wdata = 32'h99;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("wait_no_ready", 32'(ready), 0);
        check("wait_wdata", 32'(w_data), 32'h99);
        reset = 1'b0;
        #1;
        check("rstw_ready", 32'(ready), 0);
        check("rstw_wr", 32'(wr_uart), 0);
        check("rstw_wdata", 32'(w_data), 0);
        check("rstw_irq", 32'(irq), 0);
        sel = 0; we = 0; tx_full = 1'b0;
        ctrl_m = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        nwr_v = 0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (wr_uart) nwr_v++;
        end
        check("rstw_no_wr", 32'(nwr_v), 0);

        // Randomized accesses against the register-map model
        for (int i = 0; i < 60; i++) begin
            logic        w, rxe, txf;
            logic [4:0]  a;
            logic [31:0] d, exp_rd;
            logic [7:0]  rdb;
            logic        irq_e;
            int          st;
            w   = 1'($urandom_range(0, 1));
            a   = 5'($urandom_range(0, 31));
            d   = $urandom;
            rdb = 8'($urandom);
            rxe = 1'($urandom_range(0, 1));
            txf = 1'($urandom_range(0, 1));
            @(negedge clk);
            r_data = rdb; rx_empty = rxe; tx_full = txf;
            @(negedge clk);
            irq_e = irq_model(ctrl_m, rxe, txf);
            check("rand_irq", 32'(irq), 32'(irq_e));
            st = (w && a / 4 == 0 && txf) ? $urandom_range(1, 4) : 0;
            exp_rd = read_model(a, rxe, rdb, txf, irq_e, ctrl_m);
            access(w, a, d, st, rd_v, lat_v, nrd_v, nwr_v, wd_v, nrdy_v);
            check("rand_lat", 32'(lat_v), 32'(2 + st));
            check("rand_nrdy", 32'(nrdy_v), 1);
            check("rand_nwr", 32'(nwr_v), (w && a / 4 == 0) ? 1 : 0);
            check("rand_nrd", 32'(nrd_v), (!w && a / 4 == 1 && !rxe) ? 1 : 0);
            if (w && a / 4 == 0) check("rand_wdata", 32'(wd_v), 32'(d[7:0]));
            if (!w) check("rand_rdata", rd_v, exp_rd);
`ifdef UART_IRQ_EN
            if (w && a / 4 == 3) ctrl_m = d[1:0];
`endif
        end

        check("strobe_overlap", 32'(overlap), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
